// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared types and constants for the SCAN elevator controller.
//   - state_t : controller state (IDLE, MOVING, OPEN)
//   - DIR_UP / DIR_DOWN : encoding of the travel-direction register
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_OPEN   = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_chk.sv
// elevator_chk
//   Simulation checks for the elevator controller.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     step_up, step_down  : the cabin steps one floor on this edge
//     floor               : current floor index
//     up, down            : motor drive outputs
module elevator_chk #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_up,
    input  logic               step_down,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               up,
    input  logic               down
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

    // Cabin never steps past the shaft ends; motor directions never overlap.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(step_up && (floor == TOP_FLOOR)));
            assert (!(step_down && (floor == {FLOOR_W{1'b0}})));
            assert (!(up && down));
        end
    end

endmodule

// File: rtl/elevator_req_reg.sv
// elevator_req_reg
//   Latches floor requests into the pending vector and reports whether any
//   pending request lies above or below the current floor.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     req       : raw floor requests (bit i = floor i)
//     served    : bits that must be cleared / not latched this cycle
//     floor     : current floor index
//     pending   : latched, unserved requests
//     above     : some pending bit is above floor
//     below     : some pending bit is below floor
module elevator_req_reg
    import elevator_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  req,
    input  logic [FLOORS-1:0]  served,
    input  logic [FLOOR_W-1:0] floor,
    output logic [FLOORS-1:0]  pending,
    output logic               above,
    output logic               below
);

    logic [FLOORS-1:0] r_pending;
    logic [FLOORS-1:0] w_above_mask;
    logic [FLOORS-1:0] w_below_mask;

    // Pending request register: accumulate new requests, drop served ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= {FLOORS{1'b0}};
        end else begin
            r_pending <= (r_pending | req) & ~served;
        end
    end

    // Masks selecting the floors strictly above / below the current floor.
    always_comb begin
        w_above_mask = {FLOORS{1'b0}};
        w_below_mask = {FLOORS{1'b0}};
        for (int i = 0; i < FLOORS; i++) begin
            w_above_mask[i] = (i > int'(floor));
            w_below_mask[i] = (i < int'(floor));
        end
    end

    assign pending = r_pending;
    assign above   = |(r_pending & w_above_mask);
    assign below   = |(r_pending & w_below_mask);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl
//   N-floor elevator controller serving latched requests in SCAN order.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     req       : floor requests, pulse or level (bit i = floor i)
//     inopen    : door-open button
//     inclose   : door-close button
//     overload  : cabin overload, holds the door open
//     open      : door-open drive (registered)
//     close     : door-closed drive, always ~open
//     up, down  : motor drives (registered, mutually exclusive)
//     floor     : current floor
//     pending   : latched, unserved requests
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = $clog2(FLOORS),
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  req,
    input  logic               inopen,
    input  logic               inclose,
    input  logic               overload,
    output logic               open,
    output logic               close,
    output logic               up,
    output logic               down,
    output logic [FLOOR_W-1:0] floor,
    output logic [FLOORS-1:0]  pending
);

    localparam int TRAVEL_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DOOR_W   = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYC - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0]  FLOOR_ONE   = FLOOR_W'(1);

    state_t              r_state;
    logic                r_dir;
    logic [FLOOR_W-1:0]  r_floor;
    logic [TRAVEL_W-1:0] r_travel_cnt;
    logic [DOOR_W-1:0]   r_door_cnt;
    logic                r_open;
    logic                r_up;
    logic                r_down;

    logic [FLOORS-1:0]   w_pending;
    logic [FLOORS-1:0]   w_served;
    logic                w_above;
    logic                w_below;
    logic                w_dir_pend;
    logic                w_opp_pend;
    logic [FLOOR_W-1:0]  w_step_floor;
    logic                w_travel_done;
    logic                w_door_hold;
    logic                w_door_expire;
    logic                w_enter_open;
    logic [FLOOR_W-1:0]  w_open_floor;
    logic                w_step_up;
    logic                w_step_down;

    elevator_req_reg #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .served  (w_served),
        .floor   (r_floor),
        .pending (w_pending),
        .above   (w_above),
        .below   (w_below)
    );

    assign w_dir_pend    = (r_dir == DIR_UP) ? w_above : w_below;
    assign w_opp_pend    = (r_dir == DIR_UP) ? w_below : w_above;
    assign w_step_floor  = (r_dir == DIR_UP) ? (r_floor + FLOOR_ONE) : (r_floor - FLOOR_ONE);
    assign w_travel_done = (r_travel_cnt == {TRAVEL_W{1'b0}});
    // A request for the floor the door is open at behaves like inopen.
    assign w_door_hold   = inopen | overload | req[r_floor];
    assign w_door_expire = ~w_door_hold & (inclose | (r_door_cnt == {DOOR_W{1'b0}}));
    assign w_step_up     = (r_state == ST_MOVING) & w_travel_done & (r_dir == DIR_UP);
    assign w_step_down   = (r_state == ST_MOVING) & w_travel_done & (r_dir == DIR_DOWN);

    // Decide whether the door opens on this edge, and at which floor.
    always_comb begin
        w_enter_open = 1'b0;
        w_open_floor = r_floor;
        case (r_state)
            ST_IDLE: begin
                w_enter_open = inopen | w_pending[r_floor];
            end
            ST_MOVING: begin
                if (w_travel_done) begin
                    w_open_floor = w_step_floor;
                    w_enter_open = w_pending[w_step_floor];
                end else begin
                    w_enter_open = 1'b0;
                end
            end
            default: begin
                w_enter_open = 1'b0;
            end
        endcase
    end

    // Floor bit to drop from pending: the floor being opened at, or the floor
    // the door is already open at (so its requests are not re-latched).
    always_comb begin
        w_served = {FLOORS{1'b0}};
        if (w_enter_open) begin
            w_served[w_open_floor] = 1'b1;
        end else if (r_state == ST_OPEN) begin
            w_served[r_floor] = 1'b1;
        end else begin
            w_served = {FLOORS{1'b0}};
        end
    end

    // Controller FSM with counters and registered drive outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_UP;
            r_floor      <= {FLOOR_W{1'b0}};
            r_travel_cnt <= {TRAVEL_W{1'b0}};
            r_door_cnt   <= {DOOR_W{1'b0}};
            r_open       <= 1'b0;
            r_up         <= 1'b0;
            r_down       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_enter_open) begin
                        r_state    <= ST_OPEN;
                        r_door_cnt <= DOOR_LOAD;
                        r_open     <= 1'b1;
                    end else if (w_dir_pend) begin
                        r_state      <= ST_MOVING;
                        r_travel_cnt <= TRAVEL_LOAD;
                        r_up         <= (r_dir == DIR_UP);
                        r_down       <= (r_dir == DIR_DOWN);
                    end else if (w_opp_pend) begin
                        r_state      <= ST_MOVING;
                        r_dir        <= ~r_dir;
                        r_travel_cnt <= TRAVEL_LOAD;
                        r_up         <= (r_dir == DIR_DOWN);
                        r_down       <= (r_dir == DIR_UP);
                    end
                end
                ST_MOVING: begin
                    if (w_travel_done) begin
                        r_floor <= w_step_floor;
                        if (w_enter_open) begin
                            r_state    <= ST_OPEN;
                            r_door_cnt <= DOOR_LOAD;
                            r_open     <= 1'b1;
                            r_up       <= 1'b0;
                            r_down     <= 1'b0;
                        end else if (w_dir_pend) begin
                            // New floor not requested, so anything in the
                            // travel direction lies strictly beyond it.
                            r_travel_cnt <= TRAVEL_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_up    <= 1'b0;
                            r_down  <= 1'b0;
                        end
                    end else begin
                        r_travel_cnt <= r_travel_cnt - {{(TRAVEL_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_OPEN: begin
                    if (w_door_hold) begin
                        r_door_cnt <= DOOR_LOAD;
                    end else if (w_door_expire) begin
                        r_open <= 1'b0;
                        if (w_dir_pend) begin
                            r_state      <= ST_MOVING;
                            r_travel_cnt <= TRAVEL_LOAD;
                            r_up         <= (r_dir == DIR_UP);
                            r_down       <= (r_dir == DIR_DOWN);
                        end else if (w_opp_pend) begin
                            r_state      <= ST_MOVING;
                            r_dir        <= ~r_dir;
                            r_travel_cnt <= TRAVEL_LOAD;
                            r_up         <= (r_dir == DIR_DOWN);
                            r_down       <= (r_dir == DIR_UP);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_door_cnt <= r_door_cnt - {{(DOOR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_open  <= 1'b0;
                    r_up    <= 1'b0;
                    r_down  <= 1'b0;
                end
            endcase
        end
    end

    elevator_chk #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .step_up   (w_step_up),
        .step_down (w_step_down),
        .floor     (r_floor),
        .up        (r_up),
        .down      (r_down)
    );

    assign open    = r_open;
    assign close   = ~r_open;
    assign up      = r_up;
    assign down    = r_down;
    assign floor   = r_floor;
    assign pending = w_pending;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl
//   Self-checking bench: directed timing scenarios plus randomized traffic
//   compared against a behavioural SCAN model.
module tb_elevator_scan_ctrl;

    localparam int NF     = 8;
    localparam int T_CYC  = 4;
    localparam int D_CYC  = 6;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_OPEN = 2;

    logic          clk;
    logic          rst;
    logic [NF-1:0] req;
    logic          inopen;
    logic          inclose;
    logic          overload;
    logic          d_open;
    logic          d_close;
    logic          d_up;
    logic          d_down;
    logic [2:0]    d_floor;
    logic [NF-1:0] d_pending;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // behavioural model state
    int          m_mode;
    int          m_dir;    // +1 up, -1 down
    int          m_floor;
    int          m_left;   // cycles left at this floor / with door open
    logic [NF-1:0] m_pend;

    elevator_scan_ctrl #(
        .FLOORS     (NF),
        .FLOOR_W    (3),
        .TRAVEL_CYC (T_CYC),
        .DOOR_CYC   (D_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .inopen   (inopen),
        .inclose  (inclose),
        .overload (overload),
        .open     (d_open),
        .close    (d_close),
        .up       (d_up),
        .down     (d_down),
        .floor    (d_floor),
        .pending  (d_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit pend_beyond(input int f, input int d);
        for (int i = 0; i < NF; i++) begin
            if (m_pend[i] && (((d > 0) && (i > f)) || ((d < 0) && (i < f)))) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Leave a stop (idle or door just closed): go on, reverse, or rest.
    task automatic model_depart();
        if (pend_beyond(m_floor, m_dir)) begin
            m_mode = M_MOVE;
            m_left = T_CYC - 1;
        end else if (pend_beyond(m_floor, -m_dir)) begin
            m_dir  = -m_dir;
            m_mode = M_MOVE;
            m_left = T_CYC - 1;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    // Advance the model over one rising edge with the given inputs.
    task automatic model_step(input logic [NF-1:0] rq, input logic io, input logic ic,
                              input logic ov, input logic rs);
        logic [NF-1:0] nxt;
        if (rs) begin
            m_mode = M_IDLE; m_dir = 1; m_floor = 0; m_left = 0; m_pend = '0;
            return;
        end
        nxt = m_pend | rq;
        case (m_mode)
            M_IDLE: begin
                if (io || m_pend[m_floor]) begin
                    m_mode = M_OPEN; m_left = D_CYC - 1; nxt[m_floor] = 1'b0;
                end else begin
                    model_depart();
                end
            end
            M_MOVE: begin
                if (m_left > 0) begin
                    m_left--;
                end else begin
                    m_floor = m_floor + m_dir;
                    if (m_pend[m_floor]) begin
                        m_mode = M_OPEN; m_left = D_CYC - 1; nxt[m_floor] = 1'b0;
                    end else if (pend_beyond(m_floor, m_dir)) begin
                        m_left = T_CYC - 1;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                nxt[m_floor] = 1'b0;
                if (io || ov || rq[m_floor]) m_left = D_CYC - 1;
                else if (ic || m_left == 0) model_depart();
                else m_left--;
            end
        endcase
        m_pend = nxt;
    endtask

    // Drive one cycle of inputs, pass the edge, compare against the model.
    task automatic do_cycle(input logic [NF-1:0] rq, input logic io, input logic ic,
                            input logic ov, input logic rs);
        req = rq; inopen = io; inclose = ic; overload = ov; rst = rs;
        model_step(rq, io, ic, ov, rs);
        @(negedge clk);
        cyc++;
        check_eq("open",    d_open,    (m_mode == M_OPEN));
        check_eq("close",   d_close,   (m_mode != M_OPEN));
        check_eq("up",      d_up,      (m_mode == M_MOVE) && (m_dir > 0));
        check_eq("down",    d_down,    (m_mode == M_MOVE) && (m_dir < 0));
        check_eq("floor",   d_floor,   m_floor);
        check_eq("pending", d_pending, m_pend);
        check_eq("overlap", d_up & d_down, 0);
    endtask

    initial begin
        int c;
        int ovl_left;
        logic [NF-1:0] rq;
        logic io, ic, ov, rs;

        // reset values
        do_cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_open",    d_open,    0);
        check_eq("rst_close",   d_close,   1);
        check_eq("rst_up",      d_up,      0);
        check_eq("rst_down",    d_down,    0);
        check_eq("rst_floor",   d_floor,   0);
        check_eq("rst_pending", d_pending, 0);

        // req[3] pulse at cycle 0: travel 0->3 then one door cycle
        for (int k = 0; k < 22; k++) begin
            do_cycle((k == 0) ? 8'h08 : 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            c = k + 1;
            check_eq("s1_up",    d_up,   (c >= 2) && (c <= 13));
            check_eq("s1_open",  d_open, (c >= 14) && (c <= 19));
            check_eq("s1_floor", d_floor, (c < 6) ? 0 : (c < 10) ? 1 : (c < 14) ? 2 : 3);
            check_eq("s1_pend3", d_pending[3], (c >= 1) && (c <= 13));
        end

        // reset while travelling upward from floor 3
        do_cycle(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) do_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("mv_up", d_up, 1);
        do_cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("mrst_up",      d_up,      0);
        check_eq("mrst_floor",   d_floor,   0);
        check_eq("mrst_pending", d_pending, 0);
        check_eq("mrst_close",   d_close,   1);

        // randomized traffic against the model
        ovl_left = 0;
        for (int k = 0; k < 6000; k++) begin
            rq = '0;
            if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, NF-1)] = 1'b1;
            io = ($urandom_range(0, 29) == 0);
            ic = ($urandom_range(0, 9) == 0);
            if (ovl_left > 0) begin
                ovl_left--;
                ov = 1'b1;
            end else begin
                ov = 1'b0;
                if ($urandom_range(0, 149) == 0) ovl_left = $urandom_range(1, 25);
            end
            rs = ($urandom_range(0, 999) == 0);
            do_cycle(rq, io, ic, ov, rs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
